// File: rtl/jpeg_stream_spi_reader.sv
// ============================================================================
//  Module      : jpeg_stream_spi_reader
//  Description : Read-out stage of the JPEG encoder. After je_done it emits
//                one complete JPEG byte stream on spi_data, one byte per
//                rising edge of spi_rd. The stream is an optional 4-byte
//                length prefix, then the JFIF header from the header ROM,
//                then the entropy-coded bytes from frame memory, then the
//                EOI marker (FF D9).
//                Optional feature macro: JPEG_SPI_LEN_PREFIX_EN
//                (defined: prepend total length T = HDR_LEN + L + 2,
//                little-endian, as 4 bytes).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module jpeg_stream_spi_reader #(
   parameter int WIDTH   = 320,
   parameter int HEIGHT  = 200,
   parameter int WSZ     = $clog2(WIDTH),
   parameter int HSZ     = $clog2(HEIGHT),
   parameter int ASZ     = HSZ + WSZ,
   parameter int HDR_LEN = 623
) (
   input  logic           clk,
   input  logic           reset_n,
   input  logic           je_done,
   input  logic [ASZ-1:0] jpeg_size,
   output logic [9:0]     hd_addr,
   input  logic [7:0]     hd_data,
   output logic [ASZ-1:0] je_addr,
   input  logic [7:0]     je_data,
   input  logic           spi_rd,
   output logic [7:0]     spi_data
);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_ARM     = 3'd1;
   localparam logic [2:0] S_FETCH   = 3'd2;
   localparam logic [2:0] S_PRESENT = 3'd3;
   localparam logic [2:0] S_END     = 3'd4;

`ifdef JPEG_SPI_LEN_PREFIX_EN
   localparam logic [31:0] PRE_N = 32'd4;
`else
   localparam logic [31:0] PRE_N = 32'd0;
`endif
   // First index past the header segment.
   localparam logic [31:0] HDR_END = PRE_N + 32'(HDR_LEN);

   logic [2:0]     state_q,    state_d;
   logic [1:0]     arm_cnt_q,  arm_cnt_d;
   logic           fetch_ph_q, fetch_ph_d;
   logic [31:0]    index_q,    index_d;
   logic [31:0]    len_q,      len_d;
   logic [7:0]     spi_data_q, spi_data_d;
   logic [9:0]     hd_addr_q,  hd_addr_d;
   logic [ASZ-1:0] je_addr_q,  je_addr_d;
   logic           rd_prev_q;

   logic           rd_rise;
   logic [31:0]    data_end;
   logic [31:0]    eoi_last;
   logic [31:0]    size_ext;
   logic [7:0]     byte_sel;
   logic           addr_pre;

   assign rd_rise  = spi_rd & ~rd_prev_q;
   assign data_end = HDR_END + len_q;
   assign eoi_last = data_end + 32'd1;
   assign size_ext = {{(32-ASZ){1'b0}}, jpeg_size};

   // Byte source for the current index; ROM/memory data is valid in the
   // second FETCH cycle because the address was registered on FETCH entry.
   always_comb begin
      byte_sel = 8'hD9;
`ifdef JPEG_SPI_LEN_PREFIX_EN
      if (index_q < PRE_N) begin
         logic [31:0] total;
         total = 32'(HDR_LEN) + len_q + 32'd2;
         case (index_q[1:0])
            2'd0:    byte_sel = total[7:0];
            2'd1:    byte_sel = total[15:8];
            2'd2:    byte_sel = total[23:16];
            default: byte_sel = total[31:24];
         endcase
      end else
`endif
      if (index_q < HDR_END)       byte_sel = hd_data;
      else if (index_q < data_end) byte_sel = je_data;
      else if (index_q == data_end) byte_sel = 8'hFF;
      else                          byte_sel = 8'hD9;
   end

   // Sequencer: arm delay, two-cycle fetch, request handshake, end of stream.
   always_comb begin
      state_d    = state_q;
      arm_cnt_d  = arm_cnt_q;
      fetch_ph_d = fetch_ph_q;
      index_d    = index_q;
      len_d      = len_q;
      spi_data_d = spi_data_q;
      hd_addr_d  = hd_addr_q;
      je_addr_d  = je_addr_q;
      addr_pre   = 1'b0;

      if (je_done) begin
         // A new frame always aborts whatever is in flight.
         state_d    = S_ARM;
         arm_cnt_d  = 2'd0;
         spi_data_d = 8'h00;
      end else begin
         case (state_q)
            S_IDLE: spi_data_d = 8'h00;
            S_ARM: begin
               if (arm_cnt_q == 2'd2) begin
                  len_d      = size_ext;
                  index_d    = 32'd0;
                  fetch_ph_d = 1'b0;
                  state_d    = S_FETCH;
               end else begin
                  arm_cnt_d = arm_cnt_q + 2'd1;
               end
            end
            S_FETCH: begin
               if (!fetch_ph_q) begin
                  fetch_ph_d = 1'b1;
               end else begin
                  spi_data_d = byte_sel;
                  state_d    = S_PRESENT;
               end
            end
            S_PRESENT: begin
               if (rd_rise) begin
                  if (index_q == eoi_last) begin
                     spi_data_d = 8'h00;
                     state_d    = S_END;
                  end else begin
                     index_d    = index_q + 32'd1;
                     fetch_ph_d = 1'b0;
                     state_d    = S_FETCH;
                  end
               end
            end
            S_END:   spi_data_d = 8'h00;
            default: state_d = S_IDLE;
         endcase
      end

      // Addresses are registered on FETCH entry so memory output is ready
      // one cycle later; outside HDR/DATA they keep their last value.
`ifdef JPEG_SPI_LEN_PREFIX_EN
      addr_pre = (index_d < PRE_N);
`endif
      if ((state_d == S_FETCH) && (state_q != S_FETCH) && !addr_pre) begin
         if (index_d < HDR_END) begin
            hd_addr_d = 10'(index_d - PRE_N);
         end else if (index_d < (HDR_END + len_d)) begin
            je_addr_d = ASZ'(index_d - HDR_END);
         end
      end
   end

   // State and datapath registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= S_IDLE;
         arm_cnt_q  <= 2'd0;
         fetch_ph_q <= 1'b0;
         index_q    <= 32'd0;
         len_q      <= 32'd0;
         spi_data_q <= 8'h00;
         hd_addr_q  <= 10'd0;
         je_addr_q  <= '0;
         rd_prev_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         arm_cnt_q  <= arm_cnt_d;
         fetch_ph_q <= fetch_ph_d;
         index_q    <= index_d;
         len_q      <= len_d;
         spi_data_q <= spi_data_d;
         hd_addr_q  <= hd_addr_d;
         je_addr_q  <= je_addr_d;
         rd_prev_q  <= spi_rd;
      end
   end

   assign spi_data = spi_data_q;
   assign hd_addr  = hd_addr_q;
   assign je_addr  = je_addr_q;

endmodule

`default_nettype wire

// File: tb/tb_jpeg_stream_spi_reader.sv
// ============================================================================
//  Module      : tb_jpeg_stream_spi_reader
//  Description : Directed self-checking bench for jpeg_stream_spi_reader
//                with a 4-byte header ROM and a small frame memory.
//                Honours JPEG_SPI_LEN_PREFIX_EN for the expected stream.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_jpeg_stream_spi_reader;

   localparam int ASZ = 17;
`ifdef JPEG_SPI_LEN_PREFIX_EN
   localparam int PRE = 4;
`else
   localparam int PRE = 0;
`endif

   logic           clk = 1'b0;
   logic           reset_n;
   logic           je_done;
   logic [ASZ-1:0] jpeg_size;
   logic [9:0]     hd_addr;
   logic [7:0]     hd_data;
   logic [ASZ-1:0] je_addr;
   logic [7:0]     je_data;
   logic           spi_rd;
   logic [7:0]     spi_data;

   logic [7:0] rom [0:1023];
   logic [7:0] mem [0:15];

   int checks = 0;
   int errors = 0;

   jpeg_stream_spi_reader #(.WIDTH(320), .HEIGHT(200), .HDR_LEN(4)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .je_done   (je_done),
      .jpeg_size (jpeg_size),
      .hd_addr   (hd_addr),
      .hd_data   (hd_data),
      .je_addr   (je_addr),
      .je_data   (je_data),
      .spi_rd    (spi_rd),
      .spi_data  (spi_data)
   );

   always #5 clk = ~clk;

   // Synchronous ROM and frame memory, one cycle of read latency.
   always @(posedge clk) begin
      hd_data <= rom[hd_addr];
      je_data <= (je_addr < 16) ? mem[je_addr[3:0]] : 8'h00;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Expected k-th byte of the stream for a given data length.
   function automatic logic [7:0] exp_byte(input int l, input int k);
      int t;
      int j;
      t = 4 + l + 2;
      j = k;
      if (j < PRE) return 8'((t >> (8 * j)) & 255);
      j = j - PRE;
      if (j < 4) return rom[j];
      j = j - 4;
      if (j < l) return mem[j];
      j = j - l;
      return (j == 0) ? 8'hFF : 8'hD9;
   endfunction

   task automatic start_stream(input int l);
      jpeg_size = ASZ'(l);
      je_done   = 1'b1;
      tick();
      je_done = 1'b0;
      repeat (7) tick();
   endtask

   task automatic do_read();
      spi_rd = 1'b1;
      tick();
      spi_rd = 1'b0;
      repeat (3) tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      for (int i = 0; i < 1024; i++) rom[i] = 8'h00;
      for (int i = 0; i < 16; i++) mem[i] = 8'h00;
      rom[0] = 8'hFF; rom[1] = 8'hD8; rom[2] = 8'hFF; rom[3] = 8'hE0;
      mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33;
      reset_n   = 1'b0;
      je_done   = 1'b0;
      spi_rd    = 1'b0;
      jpeg_size = '0;
      repeat (3) tick();

      // Reset values
      check("rst_spi_data", spi_data, 8'h00);
      check("rst_hd_addr", hd_addr, 10'd0);
      check("rst_je_addr", je_addr, 17'd0);
      reset_n = 1'b1;
      tick();

      // IDLE ignores reads
      do_read();
      check("idle_read", spi_data, 8'h00);

      // Full stream, L=3
      start_stream(3);
      for (int k = 0; k < PRE + 9; k++) begin
         if (k > 0) do_read();
         check($sformatf("strA_byte%0d", k), spi_data, exp_byte(3, k));
      end
      do_read();
      check("strA_end", spi_data, 8'h00);
      do_read();
      check("strA_end_ignore", spi_data, 8'h00);
      check("strA_end_hd_hold", hd_addr, 10'd3);
      check("strA_end_je_hold", je_addr, 17'd2);

      // Asynchronous reset mid-stream
      start_stream(3);
      do_read();
      do_read();
      check("pre_rst_byte", spi_data, exp_byte(3, 2));
      #2 reset_n = 1'b0;
      #1;
      check("mid_rst_spi_data", spi_data, 8'h00);
      check("mid_rst_hd_addr", hd_addr, 10'd0);
      check("mid_rst_je_addr", je_addr, 17'd0);
      tick();
      tick();
      reset_n = 1'b1;
      do_read();
      do_read();
      check("post_rst_read", spi_data, 8'h00);

      // L=0: header then EOI, frame memory never addressed
      start_stream(0);
      for (int k = 0; k < PRE + 6; k++) begin
         if (k > 0) do_read();
         check($sformatf("L0_byte%0d", k), spi_data, exp_byte(0, k));
         check($sformatf("L0_je_addr%0d", k), je_addr, 17'd0);
      end
      do_read();
      check("L0_end", spi_data, 8'h00);

      // Read latency and held-high request
      start_stream(3);
      check("lat_byte0", spi_data, exp_byte(3, 0));
      spi_rd = 1'b1;
      tick();
      check("lat_edge0", spi_data, exp_byte(3, 0));
      tick();
      check("lat_edge1", spi_data, exp_byte(3, 0));
      tick();
      check("lat_edge2", spi_data, exp_byte(3, 1));
      repeat (7) tick();
      spi_rd = 1'b0;
      repeat (3) tick();
      check("held_one_advance", spi_data, exp_byte(3, 1));

      // Second pulse one cycle after the first is dropped
      spi_rd = 1'b1;
      tick();
      spi_rd = 1'b0;
      tick();
      spi_rd = 1'b1;
      tick();
      spi_rd = 1'b0;
      repeat (3) tick();
      check("close_pulse", spi_data, exp_byte(3, 2));

      // Advance to DATA byte 2, then restart with a new size
      for (int k = 3; k <= PRE + 6; k++) do_read();
      check("data_byte2", spi_data, 8'h33);
      start_stream(2);
      for (int k = 0; k < PRE + 8; k++) begin
         if (k > 0) do_read();
         check($sformatf("restart_byte%0d", k), spi_data, exp_byte(2, k));
      end
      do_read();
      check("restart_end", spi_data, 8'h00);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
